throw_turn_ctrl: RTL
====================

# throw_turn_ctrl

Turn sequencer for the two-player throwing game. It arbitrates the shared SPACE-driven power bar between player 0 and player 1, and gates the charge signal to the bar. It captures the bar's released force, hands a launch request to the projectile block, scores the landing and alternates turns until one player wins. It sits between the keyboard decode and the power-bar/projectile datapath, in the pixel-clock domain.

## Interface
- TURN_TIMEOUT, 650_000_000: clock cycles allowed per turn in AIM+CHARGE (10 s at 65 MHz).
- MIN_FORCE, 4: captured force below this is a dud.
- WIN_SCORE, 5: hits needed to win.
- FORCE_W, 10: force width.
- SCORE_W, 4: score width.
- clk  in  1  pixel clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- space_p0, space_p1  in  1  debounced key levels per player.
- new_game  in  1  single-cycle restart pulse.
- charge_space  out  1  registered gated SPACE to power bar.
- throw_force  in  FORCE_W  power-bar captured force; valid 2 cycles after charge_space falls.
- launch_valid  out  1  launch request.
- launch_ready  in  1  projectile block accepts.
- launch_force  out  FORCE_W  force held with launch_valid.
- launch_player  out  1  thrower index held with launch_valid.
- proj_done  in  1  single-cycle landing pulse.
- proj_hit  in  1  qualifies proj_done; 1 = target hit.
- active_player  out  1  whose turn.
- score_p0, score_p1  out  SCORE_W  hit counts.
- game_over  out  1  high in OVER.
- winner  out  1  valid while game_over.

## Operation
- Reset values: state AIM, active_player 0, scores 0, charge_space 0, launch_valid 0, launch_force 0, launch_player 0, game_over 0, winner 0, timer 0, restart_pend 0.
- Only the active player's key is observed; the other key is ignored in every state. Key edge detection uses a registered copy of the active key.
- AIM: requires a rising edge of the active key, so a key held across a turn swap does not charge. The edge sets charge_space=1 and moves to CHARGE.
- CHARGE: charge_space follows the active key. Key low clears charge_space and moves to SETTLE.
- SETTLE: exactly 2 cycles, then sample throw_force.
  - throw_force < MIN_FORCE: dud, return to AIM. Same player; timer keeps running.
  - Otherwise latch launch_force/launch_player and move to LAUNCH.
- LAUNCH: launch_valid=1. launch_force and launch_player stay stable until the cycle launch_valid && launch_ready, then move to FLIGHT. proj_done is ignored in LAUNCH.
- FLIGHT: wait for proj_done.
  - proj_hit increments the active score; scores saturate at WIN_SCORE.
  - If the new score equals WIN_SCORE, go to OVER; otherwise go to SWAP.
- SWAP: one cycle. Toggle active_player, clear the timer, go to AIM.
- OVER: game_over=1, winner=active_player. new_game clears the scores, sets active_player=0 and goes to AIM.
- Timer: counts in AIM, CHARGE and SETTLE. At TURN_TIMEOUT-1 it forces charge_space=0 and moves to SWAP; the forced throw is discarded. Timeout beats a key release in the same cycle.
- new_game in AIM/CHARGE/SETTLE/SWAP: immediate restart (scores 0, player 0, timer 0, charge_space 0, AIM).
- new_game in LAUNCH/FLIGHT sets restart_pend. The handshake completes, and the next proj_done performs the restart instead of scoring.
- new_game has priority over all other same-cycle events.

## Timing
- Key edge at cycle t gives charge_space=1 at t+1.
- Key low at t gives charge_space=0 at t+1. throw_force is sampled at t+3, and launch_valid is high at t+4.
- Launch handshake at t gives FLIGHT at t+1.
- proj_done at t gives the score update at t+1, active_player toggled at t+2, and AIM at t+2.
- All outputs are registered; no combinational input-to-output path.

## Structure
- game_pkg: state enum (AIM, CHARGE, SETTLE, LAUNCH, FLIGHT, SWAP, OVER), FORCE_W, SCORE_W, default MIN_FORCE/WIN_SCORE.
- Sub-module turn_timer: clear/enable inputs, single-cycle expire output, parameterised by TURN_TIMEOUT.
- FSM, scoring and launch registers live in throw_turn_ctrl.

## Test plan
- P0 presses, holds, releases; throw_force=60; launch_ready tied 1; proj_done with proj_hit=1 -> launch_force=60, launch_player=0, score_p0=1, active_player=1 two cycles after proj_done.
- P1 key toggles during P0 AIM, then P0 holds key through the swap -> charge_space stays 0 until P1 produces a fresh rising edge.
- Release with throw_force=3 -> no launch_valid, back to AIM, active_player stays 0.
- launch_ready held 0 for 20 cycles -> launch_valid, launch_force and launch_player stable; proj_done pulse during LAUNCH ignored.
- TURN_TIMEOUT=100, P0 holds key -> charge_space drops at cycle 100, active_player=1, no launch.
- P0 reaches 5 hits -> game_over=1, winner=0; new_game mid-FLIGHT in the next game -> no score on proj_done, scores 0, AIM, player 0.

Source files
------------

// File: rtl/throw_turn_ctrl_pkg.sv
// Shared widths, defaults, FSM encodings and score helper for the throw/turn sequencer.
package throw_turn_ctrl_pkg;

   localparam int FORCE_W       = 10;
   localparam int SCORE_W       = 4;
   localparam int MIN_FORCE_DEF = 4;
   localparam int WIN_SCORE_DEF = 5;

   localparam logic [2:0] S_AIM    = 3'd0;
   localparam logic [2:0] S_CHARGE = 3'd1;
   localparam logic [2:0] S_SETTLE = 3'd2;
   localparam logic [2:0] S_LAUNCH = 3'd3;
   localparam logic [2:0] S_FLIGHT = 3'd4;
   localparam logic [2:0] S_SWAP   = 3'd5;
   localparam logic [2:0] S_OVER   = 3'd6;

   // Saturating increment; a score never passes the winning value.
   function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s,
                                                    input logic [SCORE_W-1:0] lim);
      return (s >= lim) ? lim : s + 1'b1;
   endfunction

endpackage

// File: rtl/throw_turn_ctrl_if.sv
// Keyboard, power-bar, projectile and status signals of the turn sequencer.
interface throw_turn_ctrl_if;
   import throw_turn_ctrl_pkg::*;

   logic               space_p0;
   logic               space_p1;
   logic               new_game;
   logic               charge_space;
   logic [FORCE_W-1:0] throw_force;
   logic               launch_valid;
   logic               launch_ready;
   logic [FORCE_W-1:0] launch_force;
   logic               launch_player;
   logic               proj_done;
   logic               proj_hit;
   logic               active_player;
   logic [SCORE_W-1:0] score_p0;
   logic [SCORE_W-1:0] score_p1;
   logic               game_over;
   logic               winner;

   modport master (
      input  space_p0, space_p1, new_game, throw_force, launch_ready, proj_done, proj_hit,
      output charge_space, launch_valid, launch_force, launch_player,
             active_player, score_p0, score_p1, game_over, winner
   );

   modport slave (
      output space_p0, space_p1, new_game, throw_force, launch_ready, proj_done, proj_hit,
      input  charge_space, launch_valid, launch_force, launch_player,
             active_player, score_p0, score_p1, game_over, winner
   );

endinterface

// File: rtl/throw_turn_ctrl_turn_timer.sv
// Per-turn cycle counter; pulses expire_o on the last allowed cycle and wraps to zero.
module throw_turn_ctrl_turn_timer #(
   parameter int TURN_TIMEOUT = 650_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int CW = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TURN_TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign expire_o = en_i && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || expire_o) cnt_d = '0;
      else if (en_i)         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/throw_turn_ctrl.sv
// Turn sequencer: gates SPACE to the power bar, launches the throw, scores landings, alternates players.
module throw_turn_ctrl
   import throw_turn_ctrl_pkg::*;
#(
   parameter int TURN_TIMEOUT = 650_000_000,
   parameter int MIN_FORCE    = MIN_FORCE_DEF,
   parameter int WIN_SCORE    = WIN_SCORE_DEF
) (
   input logic               clk,
   input logic               rst_n,
   throw_turn_ctrl_if.master bus
);

   logic [2:0]         state_q, state_d;
   logic               active_q, active_d;
   logic [SCORE_W-1:0] score0_q, score0_d, score1_q, score1_d;
   logic               charge_q, charge_d;
   logic               lv_q, lv_d;
   logic [FORCE_W-1:0] lf_q, lf_d;
   logic               lp_q, lp_d;
   logic               over_q, over_d, winner_q, winner_d;
   logic               pend_q, pend_d;
   logic [1:0]         settle_q, settle_d;
   logic               key_q, key_d;

   logic               key, key_rise, expire, tmr_en, tmr_clr, restart;
   logic [SCORE_W-1:0] new_score;

   assign key       = active_q ? bus.space_p1 : bus.space_p0;
   assign key_rise  = key & ~key_q;
   assign new_score = score_inc(active_q ? score1_q : score0_q, SCORE_W'(WIN_SCORE));
   assign tmr_en    = (state_q == S_AIM) || (state_q == S_CHARGE) || (state_q == S_SETTLE);
   assign tmr_clr   = restart || (state_q == S_SWAP);

   throw_turn_ctrl_turn_timer #(.TURN_TIMEOUT(TURN_TIMEOUT)) u_turn_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (tmr_clr),
      .en_i     (tmr_en),
      .expire_o (expire)
   );

   always_comb begin
      state_d  = state_q;   active_d = active_q;
      score0_d = score0_q;  score1_d = score1_q;
      charge_d = charge_q;  lv_d     = lv_q;
      lf_d     = lf_q;      lp_d     = lp_q;
      over_d   = over_q;    winner_d = winner_q;
      pend_d   = pend_q;    settle_d = settle_q;
      restart  = 1'b0;

      case (state_q)
         S_AIM: if (key_rise) begin
            charge_d = 1'b1;
            state_d  = S_CHARGE;
         end
         S_CHARGE: begin
            charge_d = key;
            settle_d = '0;
            if (!key) state_d = S_SETTLE;
         end
         S_SETTLE: begin
            if (settle_q == 2'd2) begin
               if (bus.throw_force < FORCE_W'(MIN_FORCE)) begin
                  state_d = S_AIM;
               end else begin
                  lf_d    = bus.throw_force;
                  lp_d    = active_q;
                  lv_d    = 1'b1;
                  state_d = S_LAUNCH;
               end
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         S_LAUNCH: if (lv_q && bus.launch_ready) begin
            lv_d    = 1'b0;
            state_d = S_FLIGHT;
         end
         S_FLIGHT: if (bus.proj_done) begin
            if (pend_q) begin
               restart = 1'b1;
            end else if (bus.proj_hit) begin
               if (active_q) score1_d = new_score;
               else          score0_d = new_score;
               if (new_score == SCORE_W'(WIN_SCORE)) begin
                  over_d   = 1'b1;
                  winner_d = active_q;
                  state_d  = S_OVER;
               end else begin
                  state_d = S_SWAP;
               end
            end else begin
               state_d = S_SWAP;
            end
         end
         S_SWAP: begin
            active_d = ~active_q;
            state_d  = S_AIM;
         end
         S_OVER: ;
         default: state_d = S_AIM;
      endcase

      // Timeout wins over a same-cycle release or sample; the pending throw is dropped.
      if (expire) begin
         charge_d = 1'b0;
         lv_d     = lv_q;
         lf_d     = lf_q;
         lp_d     = lp_q;
         state_d  = S_SWAP;
      end

      if (bus.new_game) begin
         if ((state_q == S_LAUNCH) || ((state_q == S_FLIGHT) && !bus.proj_done)) pend_d = 1'b1;
         else restart = 1'b1;
      end

      if (restart) begin
         state_d  = S_AIM;
         active_d = 1'b0;
         score0_d = '0;
         score1_d = '0;
         charge_d = 1'b0;
         lv_d     = 1'b0;
         over_d   = 1'b0;
         winner_d = 1'b0;
         pend_d   = 1'b0;
         settle_d = '0;
      end

      // Track the key of whoever owns the next cycle so a key held over a swap shows no edge.
      key_d = active_d ? bus.space_p1 : bus.space_p0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_AIM;
         active_q <= 1'b0;
         score0_q <= '0;
         score1_q <= '0;
         charge_q <= 1'b0;
         lv_q     <= 1'b0;
         lf_q     <= '0;
         lp_q     <= 1'b0;
         over_q   <= 1'b0;
         winner_q <= 1'b0;
         pend_q   <= 1'b0;
         settle_q <= '0;
         key_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         active_q <= active_d;
         score0_q <= score0_d;
         score1_q <= score1_d;
         charge_q <= charge_d;
         lv_q     <= lv_d;
         lf_q     <= lf_d;
         lp_q     <= lp_d;
         over_q   <= over_d;
         winner_q <= winner_d;
         pend_q   <= pend_d;
         settle_q <= settle_d;
         key_q    <= key_d;
      end
   end

   assign bus.charge_space  = charge_q;
   assign bus.launch_valid  = lv_q;
   assign bus.launch_force  = lf_q;
   assign bus.launch_player = lp_q;
   assign bus.active_player = active_q;
   assign bus.score_p0      = score0_q;
   assign bus.score_p1      = score1_q;
   assign bus.game_over     = over_q;
   assign bus.winner        = winner_q;

endmodule
